apb_module: RTL and testbench
=============================

# apb_module

APB (AMBA 3) completer with an on-chip word-addressed memory. It sits behind an APB requester/bridge on the peripheral bus and services single read and write transfers with optional wait states. It flags out-of-range accesses with PSLVERR. All bus signals are bundled in the `dut_if` interface, which the module receives as port `d_if`.

## Interface
- `ADDR_WIDTH`, default 32: PADDR width.
- `DATA_WIDTH`, default 32: PWDATA/PRDATA width.
- `MEM_DEPTH`, default 1024: number of memory words.
- `WAIT_STATES`, default 0: PREADY-low cycles inserted before each access phase completes.

Ports, carried in `dut_if` and seen through `d_if`:
- `PCLK`  in  1  single clock; all logic on the rising edge.
- `PRESET`  in  1  reset, synchronous, active-high.
- `PSEL`  in  1  completer select.
- `PENABLE`  in  1  access-phase indicator.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PADDR`  in  ADDR_WIDTH  word index, not a byte address.
- `PWDATA`  in  DATA_WIDTH  write data.
- `PRDATA`  out  DATA_WIDTH  read data.
- `PREADY`  out  1  transfer-complete strobe.
- `PSLVERR`  out  1  error, valid only while PREADY=1.

## Operation
- FSM states: IDLE, WAIT, ACCESS. Transitions are evaluated at the PCLK rising edge.
- **IDLE**
  - If PSEL=1 and PENABLE=0 (setup phase): latch PADDR and PWRITE.
  - If the transfer is a read, load PRDATA ← mem[PADDR]; if PADDR ≥ MEM_DEPTH, load PRDATA ← 0.
  - Set PSLVERR ← (PADDR ≥ MEM_DEPTH).
  - If WAIT_STATES=0: go to ACCESS with PREADY←1. Otherwise go to WAIT with the counter set to WAIT_STATES and PREADY←0.
  - PSEL=1 with PENABLE=1 while in IDLE (access without setup) is ignored; stay in IDLE.
- **WAIT**
  - Decrement the counter each cycle.
  - When it reaches 1, go to ACCESS with PREADY←1.
- **ACCESS**
  - If PSEL=1 and PENABLE=1: the transfer completes.
  - On a write with PSLVERR=0: mem[latched addr] ← PWDATA, sampled at this edge.
  - After completion: PREADY←0, PSLVERR←0, go to IDLE.
- **Abort:** PSEL=0 in WAIT or ACCESS returns the FSM to IDLE with PREADY←0 and PSLVERR←0. No memory write occurs.
- **Back-to-back transfers:** a new setup phase in the cycle after completion is accepted from IDLE. No idle cycle is required.
- **PRDATA** holds its value until the next read setup. Writes do not change PRDATA.
- **Out-of-range writes** are dropped and signalled with PSLVERR=1.

## Timing
- **Reset** (PRESET=1 at an edge): PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, all memory words cleared to 0.
  - Reset has priority over everything; an in-flight transfer is abandoned and nothing is written.
- **Latency with WAIT_STATES=0:**
  - Setup phase seen at edge N → PREADY=1 and PRDATA valid from N until N+1.
  - The write commits at edge N+1.
- **Latency with WAIT_STATES=k:** PREADY rises k cycles later than with WAIT_STATES=0.
- **Outputs:** PREADY, PSLVERR and PRDATA are registered; no combinational input-to-output paths.

## Structure
- **Package `apb_pkg`:** FSM state enum (IDLE/WAIT/ACCESS) and default width constants.
- **`dut_if`:** interface holding all bus signals listed above.
- **Sub-module `apb_mem`:** synchronous-clear word memory with one write port and one asynchronous read port. The FSM stays in `apb_module`.

## Test plan
- **Reset:** hold PRESET=1 for 2 cycles → PRDATA=0, PREADY=0, PSLVERR=0; a read of address 500 afterwards returns 0.
- **Write then read (WAIT_STATES=0):**
  - Write: setup PADDR=500, PWDATA=123, PWRITE=1, then access.
  - Next cycle, read: setup PADDR=500, PWRITE=0, then access.
  - Required: PREADY=1 in each access cycle, PRDATA=123 during the read access, PSLVERR=0.
- **Wait states:** WAIT_STATES=2; a write then read of 7 at address 3 → PREADY low for 2 access cycles, then high; the read returns 7.
- **Out-of-range:** write 55 to PADDR=1024 → PSLVERR=1 with PREADY; a read of 1024 gives PRDATA=0 and PSLVERR=1; memory is unchanged.
- **Abort:** with WAIT_STATES=2, drop PSEL during WAIT of a write of 9 to address 10 → no write; a later read of 10 returns 0.
- **Reset mid-transfer:** PRESET=1 during the access of a write of 77 to address 20 → outputs reset; a read of 20 returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB completer.
// Holds the FSM state enum and the default bus/memory dimensions.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MEM_DEPTH   = 1024;
    localparam int DEF_WAIT_STATES = 0;

    // Bits needed to index n entries (at least 1).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_module_if.sv
// APB bus bundle between a requester (master) and this completer (slave).
// Ports: PCLK, PRESET, PSEL, PENABLE, PWRITE, PADDR, PWDATA in; PRDATA, PREADY, PSLVERR out.
interface dut_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PCLK;
    logic                  PRESET;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport slave (
        input  PCLK, PRESET, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        input  PCLK, PRESET, PRDATA, PREADY, PSLVERR,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_mem.sv
// Word memory with synchronous clear, one write port and one async read port.
// Ports: clk, rst (sync, active-high clear), we/waddr/wdata write, raddr -> rdata read.
module apb_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_module.sv
// APB completer: setup/wait/access FSM in front of a word-addressed memory.
// Ports: d_if (dut_if.slave) carrying PCLK, PRESET and all APB bus signals.
module apb_module
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    dut_if.slave d_if
);

    localparam int IDX_W = idx_width(MEM_DEPTH);
    localparam int CNT_W = idx_width(WAIT_STATES + 1);

    state_t                state;
    logic [IDX_W-1:0]      addr_q;
    logic                  write_q;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    logic                  clk;
    logic                  rst;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  commit;
    logic                  mem_we;

    assign clk = d_if.PCLK;
    assign rst = d_if.PRESET;

    // Full-width compare so high address bits never alias into the array.
    assign in_range = d_if.PADDR < ADDR_WIDTH'(MEM_DEPTH);
    assign idx      = d_if.PADDR[IDX_W-1:0];

    assign commit = (state == ACCESS) && d_if.PSEL && d_if.PENABLE;
    assign mem_we = commit && write_q && !pslverr;

    apb_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (d_if.PWDATA),
        .raddr (idx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt     <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Access without a preceding setup is ignored.
                    if (d_if.PSEL && !d_if.PENABLE) begin
                        addr_q  <= idx;
                        write_q <= d_if.PWRITE;
                        pslverr <= !in_range;
                        if (!d_if.PWRITE) begin
                            prdata <= in_range ? mem_rdata : '0;
                        end
                        if (WAIT_STATES == 0) begin
                            state  <= ACCESS;
                            pready <= 1'b1;
                        end else begin
                            state  <= WAIT;
                            cnt    <= CNT_W'(WAIT_STATES);
                            pready <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (!d_if.PSEL) begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end else if (cnt <= CNT_W'(1)) begin
                        // Counter hit 1: PREADY rises WAIT_STATES cycles late.
                        state  <= ACCESS;
                        pready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACCESS: begin
                    if (!d_if.PSEL) begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end else if (d_if.PENABLE) begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

    assign d_if.PRDATA  = prdata;
    assign d_if.PREADY  = pready;
    assign d_if.PSLVERR = pslverr;

endmodule

// File: tb/tb_apb_module.sv
// Self-checking bench for apb_module with zero and two wait states.
// Drives APB transfers and compares against a plain memory model.
module tb_apb_module;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        preset;
    bit          sel;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];

    dut_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    dut_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

    assign if0.PCLK    = clk;
    assign if0.PRESET  = preset;
    assign if0.PSEL    = psel && !sel;
    assign if0.PENABLE = penable;
    assign if0.PWRITE  = pwrite;
    assign if0.PADDR   = paddr;
    assign if0.PWDATA  = pwdata;

    assign if2.PCLK    = clk;
    assign if2.PRESET  = preset;
    assign if2.PSEL    = psel && sel;
    assign if2.PENABLE = penable;
    assign if2.PWRITE  = pwrite;
    assign if2.PADDR   = paddr;
    assign if2.PWDATA  = pwdata;

    assign o_rdata = sel ? if2.PRDATA  : if0.PRDATA;
    assign o_ready = sel ? if2.PREADY  : if0.PREADY;
    assign o_err   = sel ? if2.PSLVERR : if0.PSLVERR;

    apb_module #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MEM_DEPTH(DEPTH), .WAIT_STATES(0)
    ) u_dut0 (
        .d_if (if0)
    );

    apb_module #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MEM_DEPTH(DEPTH), .WAIT_STATES(2)
    ) u_dut2 (
        .d_if (if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int exp_waits(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
        if (a >= 32'(DEPTH)) return 32'h0;
        return mdl[d][a[9:0]];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mdl[d][i] = 32'h0;
            last_rd[d] = 32'h0;
        end
    endtask

    // Starts just after a posedge; leaves the bus idle just after the
    // completion edge so that a following call is back-to-back.
    task automatic xfer(input int d, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int waits, output bit to);
        sel = (d == 1);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        waits = 0; to = 1'b0; rd = '0; er = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        forever begin
            @(negedge clk);
            if (o_ready === 1'b1) begin
                rd = o_rdata;
                er = o_err;
                break;
            end
            waits++;
            if (waits > 20) begin
                to = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int w; bit to;
        preset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        clear_model();
        @(negedge clk);
        checks++;
        if (if0.PRDATA !== 32'h0) begin
            errors++; $display("FAIL reset_prdata0 got %h want 0", if0.PRDATA);
        end
        checks++;
        if (if0.PREADY !== 1'b0 || if0.PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags0 got rdy=%b err=%b want 0 0", if0.PREADY, if0.PSLVERR);
        end
        checks++;
        if (if2.PRDATA !== 32'h0 || if2.PREADY !== 1'b0 || if2.PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2 got d=%h rdy=%b err=%b want 0 0 0",
                     if2.PRDATA, if2.PREADY, if2.PSLVERR);
        end
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'd500, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || to) begin
            errors++; $display("FAIL reset_read500 got %h err=%b want 0 0", rd, er);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int w; bit to;
        xfer(0, 1'b1, 32'd500, 32'd123, rd, er, w, to);
        checks++;
        if (w != 0 || to || er !== 1'b0) begin
            errors++; $display("FAIL wr500 got waits=%0d err=%b want 0 0", w, er);
        end
        mdl[0][500] = 32'd123;
        checks++;
        if (rd !== last_rd[0]) begin
            errors++; $display("FAIL wr_keeps_prdata got %h want %h", rd, last_rd[0]);
        end
        xfer(0, 1'b0, 32'd500, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== 32'd123 || er !== 1'b0 || w != 0 || to) begin
            errors++;
            $display("FAIL rd500 got %h err=%b waits=%0d want 123 0 0", rd, er, w);
        end
        last_rd[0] = 32'd123;
        @(negedge clk);
        checks++;
        if (if0.PRDATA !== 32'd123 || if0.PREADY !== 1'b0) begin
            errors++;
            $display("FAIL rd500_hold got %h rdy=%b want 123 0", if0.PRDATA, if0.PREADY);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int w; bit to;
        xfer(1, 1'b1, 32'd3, 32'd7, rd, er, w, to);
        checks++;
        if (w != 2 || to || er !== 1'b0) begin
            errors++; $display("FAIL ws_wr3 got waits=%0d err=%b want 2 0", w, er);
        end
        mdl[1][3] = 32'd7;
        xfer(1, 1'b0, 32'd3, 32'h0, rd, er, w, to);
        checks++;
        if (w != 2 || to || rd !== 32'd7 || er !== 1'b0) begin
            errors++;
            $display("FAIL ws_rd3 got %h waits=%0d err=%b want 7 2 0", rd, w, er);
        end
        last_rd[1] = 32'd7;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int w; bit to;
        xfer(0, 1'b1, 32'd1024, 32'd55, rd, er, w, to);
        checks++;
        if (er !== 1'b1 || w != 0 || to) begin
            errors++; $display("FAIL oor_wr got err=%b waits=%0d want 1 0", er, w);
        end
        xfer(0, 1'b0, 32'd1024, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1 || to) begin
            errors++; $display("FAIL oor_rd got %h err=%b want 0 1", rd, er);
        end
        last_rd[0] = 32'h0;
        xfer(0, 1'b0, 32'd0, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== mdl[0][0] || er !== 1'b0 || to) begin
            errors++; $display("FAIL oor_alias0 got %h err=%b want %h 0", rd, er, mdl[0][0]);
        end
        last_rd[0] = mdl[0][0];
        xfer(1, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, rd, er, w, to);
        checks++;
        if (er !== 1'b1 || w != 2 || to) begin
            errors++; $display("FAIL oor_wr_max got err=%b waits=%0d want 1 2", er, w);
        end
        xfer(1, 1'b0, 32'd1023, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== mdl[1][1023] || er !== 1'b0 || to) begin
            errors++; $display("FAIL oor_alias1023 got %h err=%b want %h 0", rd, er, mdl[1][1023]);
        end
        last_rd[1] = mdl[1][1023];
    endtask

    task automatic test_no_setup();
        sel = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 32'd40; pwdata = 32'd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if0.PREADY !== 1'b0) begin
                errors++; $display("FAIL no_setup_rdy cyc=%0d got %b want 0", i, if0.PREADY);
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int w; bit to;
        sel = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'd10; pwdata = 32'd9;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        checks++;
        if (if2.PREADY !== 1'b0) begin
            errors++; $display("FAIL abort_wait_rdy got %b want 0", if2.PREADY);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (if2.PREADY !== 1'b0 || if2.PSLVERR !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle got rdy=%b err=%b want 0 0", if2.PREADY, if2.PSLVERR);
            end
        end
        @(posedge clk); #1;
        pwrite = 1'b0;
        xfer(1, 1'b0, 32'd10, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || w != 2 || to) begin
            errors++; $display("FAIL abort_rd10 got %h err=%b waits=%0d want 0 0 2", rd, er, w);
        end
        last_rd[1] = 32'h0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int w; bit to;
        sel = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'd20; pwdata = 32'd77;
        @(posedge clk); #1;
        penable = 1'b1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        clear_model();
        @(negedge clk);
        checks++;
        if (if0.PRDATA !== 32'h0 || if0.PREADY !== 1'b0 || if0.PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out got d=%h rdy=%b err=%b want 0 0 0",
                     if0.PRDATA, if0.PREADY, if0.PSLVERR);
        end
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'd20, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || to) begin
            errors++; $display("FAIL rst_mid_rd20 got %h err=%b want 0 0", rd, er);
        end
        xfer(0, 1'b0, 32'd500, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== 32'h0 || to) begin
            errors++; $display("FAIL rst_mid_rd500 got %h want 0", rd);
        end
        xfer(1, 1'b0, 32'd3, 32'h0, rd, er, w, to);
        checks++;
        if (rd !== 32'h0 || to) begin
            errors++; $display("FAIL rst_mid_rd3_dut2 got %h want 0", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd; logic er, exp_er; int w; bit to;
        int d; bit wr;
        for (int i = 0; i < 80; i++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: a = 32'($urandom_range(0, 15));
                1: a = 32'($urandom_range(1018, 1030));
                default: a = $urandom;
            endcase
            wd = $urandom;
            exp_er = (a >= 32'(DEPTH));
            exp_rd = wr ? last_rd[d] : model_rd(d, a);
            xfer(d, wr, a, wd, rd, er, w, to);
            checks++;
            if (w != exp_waits(d) || to) begin
                errors++; $display("FAIL rnd_waits i=%0d got %0d want %0d", i, w, exp_waits(d));
            end
            checks++;
            if (er !== exp_er) begin
                errors++; $display("FAIL rnd_err i=%0d a=%h got %b want %b", i, a, er, exp_er);
            end
            checks++;
            if (rd !== exp_rd) begin
                errors++;
                $display("FAIL rnd_rdata i=%0d wr=%b a=%h got %h want %h", i, wr, a, rd, exp_rd);
            end
            if (wr && !exp_er) mdl[d][a[9:0]] = wd;
            if (!wr) last_rd[d] = exp_rd;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_out_of_range();
        test_no_setup();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
